// File: rtl/i2s_stereo_rx.sv
// I2S stereo receiver: deserializes ws/sd into left/right words, pairs them
// into frames and hands them downstream through a 2-entry valid/ready FIFO.
//
// state | meaning
// SYNC  | waiting for the first ws fall (start of a left word); data discarded
// LEFT  | collecting the left word
// RIGHT | collecting the right word; its completion pushes a frame
module i2s_stereo_rx #(
    parameter int BITS_PRECISION = 24,
    parameter int FIFO_DEPTH     = 2
) (
    input  logic                      sck,
    input  logic                      rst,
    input  logic                      ws,
    input  logic                      sd,
    output logic [BITS_PRECISION-1:0] l_data,
    output logic [BITS_PRECISION-1:0] r_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic                      overflow,
    output logic                      short_word,
    output logic                      locked
);
    localparam int CW = $clog2(BITS_PRECISION + 1);
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int NW = $clog2(FIFO_DEPTH + 1);
    localparam int FW = 2 * BITS_PRECISION;
    localparam logic [CW-1:0] CNT_MAX   = CW'(BITS_PRECISION);
    localparam logic [CW-1:0] CNT_SHORT = CW'(BITS_PRECISION - 1);

    typedef enum logic [1:0] {SYNC, LEFT, RIGHT} state_t;

    state_t                    state, state_next;
    logic                      ws_prev;
    logic                      boundary;
    logic [CW-1:0]             bit_cnt;
    logic [BITS_PRECISION-1:0] shreg;
    logic [BITS_PRECISION-1:0] word;
    logic [BITS_PRECISION-1:0] left_word;
    logic                      latch_left;
    logic                      frame_done;
    logic                      push_pend;
    logic [FW-1:0]             push_data;

    logic [FW-1:0]             mem [FIFO_DEPTH];
    logic [PW-1:0]             rd_ptr, wr_ptr;
    logic [NW-1:0]             count;
    logic                      pop, push, full;
    logic [NW-1:0]             remain;

    assign boundary  = (ws != ws_prev);
    assign out_valid = (count != '0);
    assign pop       = out_valid & out_ready;
    assign full      = (count == NW'(FIFO_DEPTH));
    assign push      = push_pend & (~full | pop);
    assign remain    = count - NW'(pop);

    // Current word including this edge's bit, left-aligned; extra bits beyond the word width are dropped
    always_comb begin
        word = shreg;
        if (bit_cnt < CNT_MAX) begin
            for (int i = 0; i < BITS_PRECISION; i++) begin
                if (i == BITS_PRECISION - 1 - int'(bit_cnt)) begin
                    word[i] = sd;
                end
            end
        end
    end

    // Next-state and word routing; only boundaries move the FSM
    always_comb begin
        state_next = state;
        latch_left = 1'b0;
        frame_done = 1'b0;
        if (boundary) begin
            case (state)
                SYNC: begin
                    if (!ws) begin
                        state_next = LEFT;
                    end
                end
                LEFT: begin
                    latch_left = 1'b1;
                    state_next = RIGHT;
                end
                RIGHT: begin
                    frame_done = 1'b1;
                    state_next = LEFT;
                end
                default: state_next = SYNC;
            endcase
        end
    end

    // State register
    always_ff @(posedge sck or posedge rst) begin
        if (rst) begin
            state <= SYNC;
        end else begin
            state <= state_next;
        end
    end

    // Deserializer, left-word latch and one-cycle-delayed frame push request
    always_ff @(posedge sck or posedge rst) begin
        if (rst) begin
            ws_prev    <= 1'b1;
            bit_cnt    <= '0;
            shreg      <= '0;
            left_word  <= '0;
            push_pend  <= 1'b0;
            push_data  <= '0;
            short_word <= 1'b0;
            locked     <= 1'b0;
        end else begin
            ws_prev    <= ws;
            short_word <= boundary && (state != SYNC) && (bit_cnt < CNT_SHORT);
            if (boundary) begin
                shreg   <= '0;
                bit_cnt <= '0;
            end else begin
                shreg <= word;
                if (bit_cnt < CNT_MAX) begin
                    bit_cnt <= bit_cnt + 1'b1;
                end
            end
            if (latch_left) begin
                left_word <= word;
            end
            push_pend <= frame_done;
            if (frame_done) begin
                push_data <= {left_word, word};
            end
            if (state == SYNC && state_next == LEFT) begin
                locked <= 1'b1;
            end
        end
    end

    // FIFO storage; contents need no reset since count gates visibility
    always_ff @(posedge sck) begin
        if (push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // FIFO control and registered head, which holds its last value when empty
    always_ff @(posedge sck or posedge rst) begin
        if (rst) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
            l_data   <= '0;
            r_data   <= '0;
        end else begin
            overflow <= push_pend & full & ~pop;
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count + NW'(push) - NW'(pop);
            if (remain != '0) begin
                {l_data, r_data} <= mem[rd_ptr + PW'(pop)];
            end else if (push) begin
                {l_data, r_data} <= push_data;
            end
        end
    end
endmodule
